// File: rtl/mole_pkg.sv
// mole_pkg: shared definitions for the whack-a-hole round controller.
//   state_t          - FSM state encoding (IDLE, RUN, OVER)
//   GAME_SEC_DEFAULT - default game length in ticks
//   bcd2_inc()       - two-digit BCD increment that sticks at 99
//   onehot4()        - 2-bit hole index to one-hot 4-bit LED pattern
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int GAME_SEC_DEFAULT = 30;

    // Increment {tens, ones}; ones wraps 9 -> 0 with carry, 99 holds.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mole_game_ctrl_edge_det.sv
// edge_det: rising-edge detector for debounced level inputs.
//   clk  - system clock
//   clr  - asynchronous active-low reset
//   d    - level inputs, WIDTH bits
//   rise - one-cycle pulse per bit on a 0 -> 1 transition
// The history resets to all ones so a level already high when reset
// releases is treated as old and never produces a pulse.
module edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '1;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: round controller for the whack-a-hole game.
//   clk       - system clock
//   clr       - asynchronous active-low reset
//   tick      - one-cycle pulse per game second
//   start     - start/restart button level (debounced)
//   btn       - hole button levels, btn[i] is hole i (debounced)
//   seq       - hole index from the sequence generator
//   mole      - one-hot mole LEDs, zero when no mole is lit
//   score     - BCD hit count {tens, ones}
//   time_left - remaining seconds, binary
//   hit       - one-cycle pulse on a scored hit
//   miss      - one-cycle pulse on a wrong press
//   game_over - high while the game is finished
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int GAME_SEC = GAME_SEC_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic [1:0] seq,
    output logic [3:0] mole,
    output logic [7:0] score,
    output logic [5:0] time_left,
    output logic       hit,
    output logic       miss,
    output logic       game_over
);

    state_t     state, state_next;
    logic       armed, armed_next;
    logic [3:0] mole_next;
    logic [7:0] score_next;
    logic [5:0] time_next;
    logic       hit_next, miss_next;
    logic       start_rise;
    logic [3:0] btn_rise;

    edge_det #(.WIDTH(1)) u_start_edge (
        .clk  (clk),
        .clr  (clr),
        .d    (start),
        .rise (start_rise)
    );

    edge_det #(.WIDTH(4)) u_btn_edge (
        .clk  (clk),
        .clr  (clr),
        .d    (btn),
        .rise (btn_rise)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            armed     <= 1'b0;
            mole      <= 4'd0;
            score     <= 8'h00;
            time_left <= 6'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            armed     <= armed_next;
            mole      <= mole_next;
            score     <= score_next;
            time_left <= time_next;
            hit       <= hit_next;
            miss      <= miss_next;
            game_over <= (state_next == OVER);
        end
    end

    // The press is judged first against the currently lit mole; a tick in
    // the same cycle is applied afterwards so its mole load or OVER entry
    // overrides mole/armed while the press keeps its score and pulse.
    // While armed, mole is one-hot, so an exact match with the edge set
    // means exactly one edge on the lit hole.
    always_comb begin
        state_next = state;
        armed_next = armed;
        mole_next  = mole;
        score_next = score;
        time_next  = time_left;
        hit_next   = 1'b0;
        miss_next  = 1'b0;

        case (state)
            IDLE, OVER: begin
                mole_next  = 4'd0;
                armed_next = 1'b0;
                if (start_rise) begin
                    score_next = 8'h00;
                    time_next  = 6'(GAME_SEC);
                    mole_next  = onehot4(seq);
                    armed_next = 1'b1;
                    state_next = RUN;
                end
            end

            RUN: begin
                if (armed && (btn_rise != 4'd0)) begin
                    if (btn_rise == mole) begin
                        score_next = bcd2_inc(score);
                        hit_next   = 1'b1;
                    end else begin
                        miss_next  = 1'b1;
                    end
                    mole_next  = 4'd0;
                    armed_next = 1'b0;
                end
                if (tick) begin
                    time_next = time_left - 6'd1;
                    if (time_next != 6'd0) begin
                        mole_next  = onehot4(seq);
                        armed_next = 1'b1;
                    end else begin
                        mole_next  = 4'd0;
                        armed_next = 1'b0;
                        state_next = OVER;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                mole_next  = 4'd0;
                armed_next = 1'b0;
            end
        endcase
    end

endmodule
